// File: rtl/serial_deframer.sv
// Serial frame deframer: hunts for a 4-bit sync word, collects DATA_W payload
// bits MSB first, then checks one even-parity bit before publishing the payload.
module serial_deframer #(
    parameter logic [3:0] SYNC_WORD = 4'b1101,
    parameter int         DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              sync_lock
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [3:0]        window_q,     window_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] payload_q,    payload_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;

    logic [3:0] window_next;
    assign window_next = {window_q[2:0], din};

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        window_d     = window_q;
        bit_cnt_d    = bit_cnt_q;
        payload_d    = payload_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;

        if (bit_en) begin
            case (state_q)
                HUNT: begin
                    window_d = window_next;
                    if (window_next == SYNC_WORD) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    payload_d = DATA_W'({payload_q, din});
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    // Even parity: payload plus parity bit must XOR to zero.
                    if ((^payload_q ^ din) == 1'b0) begin
                        data_out_d   = payload_q;
                        data_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                    state_d   = HUNT;
                    window_d  = '0;
                    bit_cnt_d = '0;
                end
                default: begin
                    state_d  = HUNT;
                    window_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            window_q     <= '0;
            bit_cnt_q    <= '0;
            payload_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            bit_cnt_q    <= bit_cnt_d;
            payload_q    <= payload_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign sync_lock  = (state_q == DATA) || (state_q == PARITY);

endmodule

// File: doc/serial_deframer.md
SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 4'b1101, meaning the 4-bit frame sync pattern, received MSB first; the value 4'b0000 is illegal.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port din, input, 1 bit: the serial bit stream, driven by the upstream master-slave flop q output.
REQ-006 The block SHALL have port bit_en, input, 1 bit: din is consumed only on rising edges where bit_en=1.
REQ-007 The block SHALL have port data_out, output, DATA_W bits: the last good payload.
REQ-008 The block SHALL have port data_valid, output, 1 bit: a one-cycle pulse when data_out is updated.
REQ-009 The block SHALL have port parity_err, output, 1 bit: a one-cycle pulse when a frame is rejected.
REQ-010 The block SHALL have port sync_lock, output, 1 bit: high while in state DATA or PARITY.

Function
REQ-011 The block SHALL implement a state machine with states HUNT, DATA and PARITY.
REQ-012 The block SHALL leave all state, counters, window and outputs unchanged on edges where bit_en=0, except that data_valid and parity_err clear.
REQ-013 HUNT SHALL shift din into a 4-bit window (new bit in at the LSB); when {window[2:0],din}==SYNC_WORD, the block SHALL go to DATA with bit_cnt=0 on that edge.
REQ-014 HUNT sync detection SHALL be overlapping: for example, stream 1,1,1,0,1 matches at the 5th bit.
REQ-015 DATA SHALL shift din into a payload register MSB first and increment bit_cnt; on the edge that takes the DATA_W-th bit, the block SHALL go to PARITY.
REQ-016 PARITY SHALL consume one bit; even parity SHALL be checked over the payload plus that bit (XOR of all DATA_W+1 bits equals 0).
REQ-017 On parity pass, data_out SHALL take the payload and data_valid SHALL be 1 in the cycle after the parity-bit edge.
REQ-018 On parity fail, data_out SHALL be held and parity_err SHALL be 1 in the cycle after the parity-bit edge.
REQ-019 After PARITY, the block SHALL return to HUNT with window cleared to 0; the sync bits of the next frame may immediately follow the parity bit.
REQ-020 The total latency SHALL be 4+DATA_W+1 consumed bits from the first sync bit to the parity edge, with the output visible one cycle later.
REQ-021 data_valid and parity_err SHALL never both be 1 in the same cycle, and each SHALL last exactly one clk cycle.
REQ-022 Bits inside DATA and PARITY SHALL NOT be checked for sync; there is no resync mid-frame.

Reset
REQ-023 When reset=1, the block SHALL immediately, without a clock edge, go to state HUNT with window=0, bit_cnt=0, payload=0, data_out=0, data_valid=0, parity_err=0 and sync_lock=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require a full SYNC_WORD before accepting data.
REQ-025 The first edge after reset deassertion with bit_en=1 SHALL be treated as a normal HUNT bit.

Verification
REQ-026 Good frame: with bit_en=1, din=1,1,0,1 then 1,0,1,0,0,1,0,1 (0xA5), parity 0 -> sync_lock rises after the 4th bit; data_out=0xA5 and data_valid=1 for exactly one cycle after the 13th bit.
REQ-027 Bad parity: the same frame with parity bit 1 -> parity_err=1 for one cycle; data_out stays 0x00; data_valid stays 0.
REQ-028 Gapped enable: the good frame with bit_en=0 for 3 cycles between each bit -> data_out=0xA5 with a single data_valid pulse; no output change during gaps.
REQ-029 Overlap and back-to-back: din=1,1,1,0,1 + 0x3C + parity 0, then immediately 1,1,0,1 + 0xFF + parity 0 -> data_valid pulses with data_out=0x3C, then 0xFF.
REQ-030 Reset mid-frame: assert reset asynchronously (between edges) after 5 payload bits -> outputs are zero at once; post-reset payload bits without sync produce no data_valid.
